edge_detect_multi: RTL and testbench

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi.sv | 114 +++++++++++
 tb/tb_edge_detect_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel Moore FSMs with a saturating edge counter.
// Define EDGE_DETECT_MULTI_SYNC_EN to add a 2-flop input synchroniser per channel.
module edge_detect_multi #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     level,
    input  logic [1:0]       mode,
    input  logic             cnt_clr,
    output logic [N-1:0]     tick,
    output logic             any_tick,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam logic [1:0] ZERO = 2'd0;
    localparam logic [1:0] RISE = 2'd1;
    localparam logic [1:0] ONE  = 2'd2;
    localparam logic [1:0] FALL = 2'd3;

    // Wide enough for edge_cnt plus a full popcount of N ticks.
    localparam int SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX =
        {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [N-1:0]     samp;
    logic [1:0]       state_q [N];
    logic [1:0]       state_d [N];
    logic [CNT_W-1:0] edge_cnt_q;
    logic [CNT_W-1:0] edge_cnt_d;
    logic [SUM_W-1:0] pop;
    logic [SUM_W-1:0] sum;

`ifdef EDGE_DETECT_MULTI_SYNC_EN
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync1_d;
    logic [N-1:0] sync2_q;
    logic [N-1:0] sync2_d;

    always_comb begin
        sync1_d = level;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = level;
`endif

    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = ZERO;
            unique case (state_q[i])
                ZERO:    state_d[i] = samp[i] ? RISE : ZERO;
                RISE:    state_d[i] = samp[i] ? ONE  : FALL;
                ONE:     state_d[i] = samp[i] ? ONE  : FALL;
                FALL:    state_d[i] = samp[i] ? RISE : ZERO;
                default: state_d[i] = ZERO;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            tick[i] = ((state_q[i] == RISE) && mode[0]) ||
                      ((state_q[i] == FALL) && mode[1]);
        end
    end

    assign any_tick = |tick;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + SUM_W'(tick[i]);
        end
        sum = SUM_W'(edge_cnt_q) + pop;
        if (cnt_clr) begin
            edge_cnt_d = '0;
        end else if (sum > CNT_MAX) begin
            edge_cnt_d = {CNT_W{1'b1}};
        end else begin
            edge_cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ZERO;
            end
            edge_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
            end
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: directed edge cases then random traffic
// against a sample-history reference model (two instances: CNT_W=8 and CNT_W=2).
module tb_edge_detect_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] level;
    logic [1:0] mode;
    logic       cnt_clr;
    logic [3:0] tick_a;
    logic       any_a;
    logic [7:0] cnt_a;
    logic [3:0] tick_b;
    logic       any_b;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Model: last two samples seen by the detector, plus counters.
    logic [3:0] cur;
    logic [3:0] prev;
    logic [3:0] s1;
    logic [3:0] s2;
    int         mc8;
    int         mc2;

    always #5 clk = ~clk;

    edge_detect_multi #(.N(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .level(level), .mode(mode),
        .cnt_clr(cnt_clr), .tick(tick_a), .any_tick(any_a),
        .edge_cnt(cnt_a)
    );

    edge_detect_multi #(.N(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .level(level), .mode(mode),
        .cnt_clr(cnt_clr), .tick(tick_b), .any_tick(any_b),
        .edge_cnt(cnt_b)
    );

    function automatic logic [3:0] exp_tick();
        return ((cur & ~prev) & {4{mode[0]}}) |
               ((~cur & prev) & {4{mode[1]}});
    endfunction

    function automatic int popc(logic [3:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [3:0] t;
        t = reset ? 4'b0 : exp_tick();
        chk({tag, ".tick_a"}, 32'(tick_a), 32'(t));
        chk({tag, ".any_a"}, 32'(any_a), 32'(|t));
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(mc8));
        chk({tag, ".tick_b"}, 32'(tick_b), 32'(t));
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(mc2));
    endtask

    task automatic model_reset();
        cur  = '0;
        prev = '0;
        s1   = '0;
        s2   = '0;
        mc8  = 0;
        mc2  = 0;
    endtask

    task automatic step(string tag, logic [3:0] lv, logic [1:0] md,
                        logic clr, logic r);
        int p;
        @(negedge clk);
        level   = lv;
        mode    = md;
        cnt_clr = clr;
        reset   = r;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            p   = popc(exp_tick());
            mc8 = clr ? 0 : ((mc8 + p > 255) ? 255 : mc8 + p);
            mc2 = clr ? 0 : ((mc2 + p > 3) ? 3 : mc2 + p);
            prev = cur;
`ifdef EDGE_DETECT_MULTI_SYNC_EN
            cur = s2;
            s2  = s1;
            s1  = lv;
`else
            cur = lv;
`endif
        end
        #1;
        check_all(tag);
    endtask

    task automatic mid_reset(string tag);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".tick_a"}, 32'(tick_a), 32'h0);
        chk({tag, ".any_a"}, 32'(any_a), 32'h0);
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'h0);
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'h0);
    endtask

    initial begin
        reset   = 1'b1;
        level   = '0;
        mode    = 2'b01;
        cnt_clr = 1'b0;
        model_reset();
        #3;
        check_all("rst_async");

        // Level held high through reset release: rising tick on all lanes.
        step("rst_hold", 4'hF, 2'b01, 1'b0, 1'b1);
        step("rel_rise", 4'hF, 2'b01, 1'b0, 1'b0);
        step("rel_hold", 4'hF, 2'b01, 1'b0, 1'b0);
        step("rel_fall", 4'h0, 2'b01, 1'b0, 1'b0);
        step("idle", 4'h0, 2'b01, 1'b1, 1'b0);

        // Single lane rise with rising-only mode; later fall ignored.
        step("r0_rise", 4'h1, 2'b01, 1'b0, 1'b0);
        step("r0_hold", 4'h1, 2'b01, 1'b0, 1'b0);
        step("r0_fall", 4'h0, 2'b01, 1'b0, 1'b0);
        step("r0_idle", 4'h0, 2'b01, 1'b0, 1'b0);

        // One-cycle pulse on lane 2 with both edges.
        step("p2_hi", 4'h4, 2'b11, 1'b0, 1'b0);
        step("p2_lo", 4'h0, 2'b11, 1'b0, 1'b0);
        step("p2_end", 4'h0, 2'b11, 1'b0, 1'b0);

        // All lanes rise together, then toggle every cycle.
        step("all_rise", 4'hF, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step("toggle", (i % 2 == 0) ? 4'h0 : 4'hF, 2'b11, 1'b0, 1'b0);
        end

        // Clear coinciding with a tick discards the increment.
        step("clr_tick", 4'h0, 2'b11, 1'b1, 1'b0);
        step("clr_after", 4'h0, 2'b11, 1'b0, 1'b0);

        // Mode 00: track level silently.
        step("m0_a", 4'hA, 2'b00, 1'b0, 1'b0);
        step("m0_b", 4'h5, 2'b00, 1'b0, 1'b0);
        step("m0_c", 4'h5, 2'b11, 1'b0, 1'b0);

        // Reset landing in the middle of a tick cycle.
        step("pre_rst", 4'hF, 2'b11, 1'b0, 1'b0);
        step("tick_rst", 4'h0, 2'b11, 1'b0, 1'b0);
        mid_reset("mid_rst");
        step("rst_lo", 4'h0, 2'b11, 1'b0, 1'b1);
        step("rel_lo", 4'h0, 2'b11, 1'b0, 1'b0);
        step("rel_lo2", 4'h0, 2'b11, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("rand", 4'($urandom), 2'($urandom),
                 ($urandom_range(0, 15) == 0), 1'b0);
            if ($urandom_range(0, 60) == 0) begin
                mid_reset("rand_rst");
                step("rand_rsth", 4'($urandom), 2'($urandom), 1'b0, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
